// File: rtl/axi_lite_pkg.sv
// Shared AXI4-lite definitions for axi_lite_ram: response codes, prot bit
// indices and the read/write channel FSM state encodings.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int unsigned PROT_PRIV   = 0;
   localparam int unsigned PROT_NONSEC = 1;
   localparam int unsigned PROT_INSTR  = 2;

   typedef enum logic [1:0] {
      W_IDLE    = 2'd0,
      W_HAVE_AW = 2'd1,
      W_HAVE_W  = 2'd2,
      W_RESP    = 2'd3
   } wr_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_RESP = 1'b1
   } rd_state_t;

endpackage

// File: rtl/byte_ram.sv
// Word-organised RAM with byte-enable write port and registered read port.
// A read and write to the same word on one edge returns the old contents.
module byte_ram #(
   parameter  int unsigned DEPTH_WORDS = 1024,
   localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rd_en,
   input  logic             rd_zero,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [31:0]      rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [31:0]      wr_data,
   input  logic [3:0]       wr_be
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // Output register is reset; rd_zero forces an error read to return zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= rd_zero ? 32'h0 : mem[rd_idx];
      end
   end

endmodule

// File: rtl/axi_lite_ram.sv
// AXI4-lite RAM responder with independent read and write channels.
// Optional AXI_RAM_PROT_CHECK_EN rejects instruction writes and unprivileged reads.
module axi_lite_ram
   import axi_lite_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] awaddress,
   input  logic [2:0]  awprot,
   input  logic        wvalid,
   output logic        wready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic        bvalid,
   input  logic        bready,
   output logic [1:0]  bresp,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddress,
   input  logic [2:0]  arprot,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   // Base is aligned to the RAM size, so range check is a compare of the upper bits.
   function automatic logic [1:0] decode_resp(input logic [31:0] addr, input logic prot_fault);
      if (addr[31:IDX_W+2] != BASE_ADDR[31:IDX_W+2]) return RESP_DECERR;
      if (addr[1:0] != 2'b00)                        return RESP_SLVERR;
      if (prot_fault)                                return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

   wr_state_t   wstate, wstate_next;
   rd_state_t   rstate, rstate_next;

   logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic [31:0] aw_addr_q, w_data_q;
   logic [3:0]  w_strb_q;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;
   logic        wr_commit;
   logic [1:0]  wr_resp, rd_resp;
   logic        wr_prot_fault, rd_prot_fault;
   logic        unused_prot;

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;
   assign ar_hs = arvalid && arready;
   assign b_hs  = bvalid && bready;
   assign r_hs  = rvalid && rready;

`ifdef AXI_RAM_PROT_CHECK_EN
   logic aw_instr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      aw_instr_q <= 1'b0;
      else if (aw_hs) aw_instr_q <= awprot[PROT_INSTR];
   end

   assign wr_prot_fault = aw_hs ? awprot[PROT_INSTR] : aw_instr_q;
   assign rd_prot_fault = !arprot[PROT_PRIV];
   assign unused_prot   = ^{awprot[1:0], arprot[2:1]};
`else
   assign wr_prot_fault = 1'b0;
   assign rd_prot_fault = 1'b0;
   assign unused_prot   = ^{awprot, arprot};
`endif

   // Second half of a write comes either from this cycle's handshake or the holding register.
   assign wr_addr   = aw_hs ? awaddress : aw_addr_q;
   assign wr_data   = w_hs  ? wdata     : w_data_q;
   assign wr_strb   = w_hs  ? wstrb     : w_strb_q;
   assign wr_resp   = decode_resp(wr_addr, wr_prot_fault);
   assign rd_resp   = decode_resp(araddress, rd_prot_fault);
   assign wr_commit = (wstate != W_RESP) && (wstate_next == W_RESP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wstate <= W_IDLE;
         rstate <= R_IDLE;
      end else begin
         wstate <= wstate_next;
         rstate <= rstate_next;
      end
   end

   always_comb begin
      wstate_next = wstate;
      rstate_next = rstate;
      unique case (wstate)
         W_IDLE: begin
            if (aw_hs && w_hs) wstate_next = W_RESP;
            else if (aw_hs)    wstate_next = W_HAVE_AW;
            else if (w_hs)     wstate_next = W_HAVE_W;
         end
         W_HAVE_AW: if (w_hs)  wstate_next = W_RESP;
         W_HAVE_W:  if (aw_hs) wstate_next = W_RESP;
         W_RESP:    if (b_hs)  wstate_next = W_IDLE;
         default:              wstate_next = W_IDLE;
      endcase
      unique case (rstate)
         R_IDLE:  if (ar_hs) rstate_next = R_RESP;
         R_RESP:  if (r_hs)  rstate_next = R_IDLE;
         default:            rstate_next = R_IDLE;
      endcase
   end

   always_comb begin
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      arready = 1'b0;
      rvalid  = 1'b0;
      unique case (wstate)
         W_IDLE:    begin awready = 1'b1; wready = 1'b1; end
         W_HAVE_AW: wready  = 1'b1;
         W_HAVE_W:  awready = 1'b1;
         W_RESP:    bvalid  = 1'b1;
         default:   ;
      endcase
      unique case (rstate)
         R_IDLE:  arready = 1'b1;
         R_RESP:  rvalid  = 1'b1;
         default: ;
      endcase
   end

   // Holding registers and responses; responses only change when a new one is issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp     <= RESP_OKAY;
         rresp     <= RESP_OKAY;
      end else begin
         if (aw_hs) aw_addr_q <= awaddress;
         if (w_hs) begin
            w_data_q <= wdata;
            w_strb_q <= wstrb;
         end
         if (wr_commit) bresp <= wr_resp;
         if (ar_hs)     rresp <= rd_resp;
      end
   end

   byte_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (ar_hs),
      .rd_zero (rd_resp != RESP_OKAY),
      .rd_idx  (araddress[IDX_W+1:2]),
      .rd_data (rdata),
      .wr_en   (wr_commit && (wr_resp == RESP_OKAY)),
      .wr_idx  (wr_addr[IDX_W+1:2]),
      .wr_data (wr_data),
      .wr_be   (wr_strb)
   );

endmodule

// File: tb/tb_axi_lite_ram.sv
// Directed bench for axi_lite_ram: vector table of single transactions plus
// hand-written split-handshake, backpressure, collision and reset sequences.
module tb_axi_lite_ram;

   logic        clk = 1'b0;
   logic        reset;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddress, wdata, araddress, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axi_lite_ram #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000)) dut (
      .clk(clk), .reset(reset),
      .awvalid(awvalid), .awready(awready), .awaddress(awaddress), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddress(araddress), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   typedef struct {
      string       name;
      logic        is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [2:0]  prot;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string n, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                               input logic [1:0] r, input logic [31:0] rd);
      vec_t v;
      v.name = n; v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.prot = p;
      v.resp = r; v.rdata = rd;
      return v;
   endfunction

   // AW and W presented together; lat counts extra cycles before bvalid.
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [2:0] p, output logic [1:0] resp, output int lat);
      int n;
      @(negedge clk);
      awvalid = 1'b1; awaddress = a; awprot = p;
      wvalid  = 1'b1; wdata = d; wstrb = s;
      n = 0;
      while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      lat = 0;
      while (!bvalid && lat < 20) begin @(negedge clk); lat++; end
      resp = bresp;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, input logic [2:0] p,
                           output logic [1:0] resp, output logic [31:0] d, output int lat);
      int n;
      @(negedge clk);
      arvalid = 1'b1; araddress = a; arprot = p;
      n = 0;
      while (!arready && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      arvalid = 1'b0;
      lat = 0;
      while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
      resp = rresp; d = rdata;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [1:0]  resp;
      logic [31:0] d;
      int          lat;

      reset = 1'b1;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      awaddress = '0; wdata = '0; wstrb = '0; awprot = '0; araddress = '0; arprot = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_readies", 32'({awready, wready, arready}), 32'h7);
      check("reset_valids",  32'({bvalid, rvalid}), 32'h0);
      check("reset_resps",   32'({bresp, rresp}), 32'h0);
      check("reset_rdata",   rdata, 32'h0);

      vecs.push_back(mk("wr_word",        1, 32'h10,   32'hDEADBEEF, 4'hF, 3'b000, 2'b00, 0));
      vecs.push_back(mk("rd_word",        0, 32'h10,   0, 0, 3'b001, 2'b00, 32'hDEADBEEF));
      vecs.push_back(mk("wr_byte0",       1, 32'h10,   32'h000000AA, 4'h1, 3'b000, 2'b00, 0));
      vecs.push_back(mk("wr_byte2",       1, 32'h10,   32'h00BB0000, 4'h4, 3'b000, 2'b00, 0));
      vecs.push_back(mk("rd_bytes",       0, 32'h10,   0, 0, 3'b001, 2'b00, 32'hDEBBBEAA));
      vecs.push_back(mk("wr_word0",       1, 32'h00,   32'hCAFEF00D, 4'hF, 3'b000, 2'b00, 0));
      vecs.push_back(mk("wr_oor",         1, 32'h1000, 32'h12345678, 4'hF, 3'b000, 2'b11, 0));
      vecs.push_back(mk("rd_alias",       0, 32'h00,   0, 0, 3'b001, 2'b00, 32'hCAFEF00D));
      vecs.push_back(mk("rd_misaligned",  0, 32'h12,   0, 0, 3'b001, 2'b10, 32'h0));
      vecs.push_back(mk("wr_misaligned",  1, 32'h12,   32'hFFFFFFFF, 4'hF, 3'b000, 2'b10, 0));
      vecs.push_back(mk("rd_after_mis",   0, 32'h10,   0, 0, 3'b001, 2'b00, 32'hDEBBBEAA));
      vecs.push_back(mk("rd_oor",         0, 32'h1000, 0, 0, 3'b001, 2'b11, 32'h0));
      vecs.push_back(mk("rd_top",         0, 32'hFFFFFFFC, 0, 0, 3'b001, 2'b11, 32'h0));
      vecs.push_back(mk("wr_word14",      1, 32'h14,   32'h01020304, 4'hF, 3'b000, 2'b00, 0));
      vecs.push_back(mk("wr_strb0",       1, 32'h14,   32'hFFFFFFFF, 4'h0, 3'b000, 2'b00, 0));
      vecs.push_back(mk("rd_strb0",       0, 32'h14,   0, 0, 3'b001, 2'b00, 32'h01020304));
      vecs.push_back(mk("wr_clear18",     1, 32'h18,   32'h00000000, 4'hF, 3'b000, 2'b00, 0));
`ifdef AXI_RAM_PROT_CHECK_EN
      vecs.push_back(mk("wr_prot",        1, 32'h18,   32'h55AA55AA, 4'hF, 3'b101, 2'b10, 0));
      vecs.push_back(mk("rd_prot_priv",   0, 32'h18,   0, 0, 3'b001, 2'b00, 32'h0));
      vecs.push_back(mk("rd_unpriv",      0, 32'h18,   0, 0, 3'b000, 2'b10, 32'h0));
`else
      vecs.push_back(mk("wr_prot",        1, 32'h18,   32'h55AA55AA, 4'hF, 3'b101, 2'b00, 0));
      vecs.push_back(mk("rd_prot_priv",   0, 32'h18,   0, 0, 3'b001, 2'b00, 32'h55AA55AA));
      vecs.push_back(mk("rd_unpriv",      0, 32'h18,   0, 0, 3'b000, 2'b00, 32'h55AA55AA));
`endif

      foreach (vecs[i]) begin
         if (vecs[i].is_wr) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].prot, resp, lat);
            check({vecs[i].name, "_bresp"}, 32'(resp), 32'(vecs[i].resp));
            check({vecs[i].name, "_blat"}, 32'(lat), 32'h0);
         end else begin
            axi_read(vecs[i].addr, vecs[i].prot, resp, d, lat);
            check({vecs[i].name, "_rresp"}, 32'(resp), 32'(vecs[i].resp));
            check({vecs[i].name, "_rdata"}, d, vecs[i].rdata);
            check({vecs[i].name, "_rlat"}, 32'(lat), 32'h0);
         end
      end

      // W first, AW three cycles later, then B held off while a new AW waits.
      @(negedge clk);
      wvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF;
      @(negedge clk);
      wvalid = 1'b0;
      check("split_wready_low", 32'(wready), 32'h0);
      check("split_awready",    32'(awready), 32'h1);
      repeat (2) begin
         @(negedge clk);
         check("split_no_b", 32'(bvalid), 32'h0);
      end
      awvalid = 1'b1; awaddress = 32'h24; awprot = 3'b000;
      @(negedge clk);
      check("split_bvalid", 32'(bvalid), 32'h1);
      check("split_bresp",  32'(bresp), 32'h0);
      awaddress = 32'h30;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_bvalid",  32'(bvalid), 32'h1);
         check("bp_bresp",   32'(bresp), 32'h0);
         check("bp_awready", 32'({awready, wready}), 32'h0);
      end
      awvalid = 1'b0; bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("bp_released", 32'({awready, wready, bvalid}), 32'h6);
      axi_read(32'h24, 3'b001, resp, d, lat);
      check("split_rdata", d, 32'h0BADF00D);

      // Read held off by rready while a new AR waits.
      @(negedge clk);
      arvalid = 1'b1; araddress = 32'h24; arprot = 3'b001;
      @(negedge clk);
      check("rbp_rvalid", 32'(rvalid), 32'h1);
      araddress = 32'h10;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rbp_hold",    32'({rvalid, arready, rresp}), 32'h8);
         check("rbp_rdata",   rdata, 32'h0BADF00D);
      end
      arvalid = 1'b0; rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      check("rbp_released", 32'({rvalid, arready}), 32'h1);

      // Write commit and read of the same word on one edge.
      axi_write(32'h20, 32'h11111111, 4'hF, 3'b000, resp, lat);
      check("coll_init_bresp", 32'(resp), 32'h0);
      @(negedge clk);
      awvalid = 1'b1; awaddress = 32'h20; wvalid = 1'b1; wdata = 32'h22222222; wstrb = 4'hF;
      arvalid = 1'b1; araddress = 32'h20; arprot = 3'b001;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("coll_both_valid", 32'({bvalid, rvalid}), 32'h3);
      check("coll_rdata_old",  rdata, 32'h11111111);
      bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      bready = 1'b0; rready = 1'b0;
      axi_read(32'h20, 3'b001, resp, d, lat);
      check("coll_rdata_new", d, 32'h22222222);

      // Reset while AW is held and a read response is pending.
      axi_write(32'h28, 32'h5A5A5A5A, 4'hF, 3'b000, resp, lat);
      check("mid_init_bresp", 32'(resp), 32'h0);
      @(negedge clk);
      awvalid = 1'b1; awaddress = 32'h28; awprot = 3'b000;
      arvalid = 1'b1; araddress = 32'h28; arprot = 3'b001;
      @(negedge clk);
      awvalid = 1'b0; arvalid = 1'b0;
      check("mid_have_aw", 32'({awready, wready, rvalid}), 32'h3);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_readies", 32'({awready, wready, arready}), 32'h7);
      check("mid_valids",  32'({bvalid, rvalid}), 32'h0);
      check("mid_rdata",   rdata, 32'h0);
      axi_read(32'h28, 3'b001, resp, d, lat);
      check("mid_word_kept", d, 32'h5A5A5A5A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
